// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter: FSM state encoding,
// requester port indices and a small helper mapping a port to its own-state.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;  // core load/store path
    localparam logic PORT1 = 1'b1;  // external loader / DMA

    // State in which the given port owns dmem.
    function automatic state_e own_state(input logic port);
        return (port == PORT1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data memory. The requester drives the
// request fields, the arbiter returns grant and read data.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that
// did not own dmem last wins. Purely combinational.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_owner,
    output logic o_valid
);

    assign o_valid = i_req0 | i_req1;
    assign o_owner = (i_req0 & i_req1) ? ~i_last_owner : (i_req1 ? PORT1 : PORT0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (m0) and the loader/DMA (m1).
// Grant is registered (no req->gnt combinational path); a holder keeps the
// memory until it drops req, or for MAX_BURST beats while the other port waits.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,     // asynchronous, active low
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          m0_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_BURST);

    state_e        r_state;
    logic [CW-1:0] r_beat_cnt;
    logic          r_last_owner;
    logic          r_gnt0;
    logic          r_gnt1;

    state_e        w_next_state;
    state_e        w_other_state;
    logic [CW-1:0] w_next_cnt;
    logic          w_own_req;
    logic          w_other_req;
    logic          w_pick_owner;
    logic          w_pick_valid;
    logic          w_beat0;
    logic          w_beat1;

    rr_pick2 u_pick (
        .i_req0       (m0.req),
        .i_req1       (m1.req),
        .i_last_owner (r_last_owner),
        .o_owner      (w_pick_owner),
        .o_valid      (w_pick_valid)
    );

    // Holder/other view of the requests, so OWN0 and OWN1 share one rule set.
    assign w_own_req     = (r_state == ST_OWN1) ? m1.req : m0.req;
    assign w_other_req   = (r_state == ST_OWN1) ? m0.req : m1.req;
    assign w_other_state = (r_state == ST_OWN1) ? ST_OWN0 : ST_OWN1;

    // Next grant state and burst count.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_next_cnt   = r_beat_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_next_state = own_state(w_pick_owner);
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_own_req) begin
                    // Holder released: hand straight over, no idle bubble.
                    w_next_state = w_other_req ? w_other_state : ST_IDLE;
                end else if (w_other_req) begin
                    if (r_beat_cnt == LAST_BEAT) w_next_state = w_other_state;
                    else if (r_beat_cnt != CNT_SAT) w_next_cnt = r_beat_cnt + 1'b1;
                end
                // Uncontested holder stays indefinitely with the count frozen.
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_next_state != r_state) w_next_cnt = '0;
    end

    // Grant FSM state, burst counter, fairness memory and registered grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_last_owner <= PORT1;  // core wins the first tie after reset
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_next_state;
            r_beat_cnt <= w_next_cnt;
            r_gnt0     <= (w_next_state == ST_OWN0);
            r_gnt1     <= (w_next_state == ST_OWN1);
            if ((w_next_state != r_state) && (w_next_state != ST_IDLE))
                r_last_owner <= (w_next_state == ST_OWN1);
        end
    end

    // A beat is a granted cycle in which the owner is still requesting.
    assign w_beat0 = r_gnt0 & m0.req;
    assign w_beat1 = r_gnt1 & m1.req;

    // Memory-side mux: zero unless the owner is actively requesting.
    assign mem_we = (w_beat0 & m0.we) | (w_beat1 & m1.we);
    assign mem_a  = w_beat0 ? m0.addr  : (w_beat1 ? m1.addr  : '0);
    assign mem_wd = w_beat0 ? m0.wdata : (w_beat1 ? m1.wdata : '0);

    // Requester-side returns.
    assign m0.gnt    = r_gnt0;
    assign m1.gnt    = r_gnt1;
    assign m0.rdata  = r_gnt0 ? mem_rd : '0;
    assign m1.rdata  = r_gnt1 ? mem_rd : '0;
    assign m0.rvalid = w_beat0 & ~m0.we;
    assign m1.rvalid = w_beat1 & ~m1.we;
    assign m0_stall  = m0.req & ~r_gnt0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a MAX_BURST=4 instance on a modelled
// memory, plus a MAX_BURST=1 instance for the strict-alternation case.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.AW(32), .DW(32)) a0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) a1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b1 ();

    logic        a_stall, a_mem_we;
    logic [31:0] a_mem_a, a_mem_wd, a_mem_rd;
    logic        b_stall, b_mem_we;
    logic [31:0] b_mem_a, b_mem_wd, b_mem_rd;

    logic [31:0] dmem [0:255];

    int n_checks;
    int n_pass;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .m0       (a0.slave),
        .m1       (a1.slave),
        .m0_stall (a_stall),
        .mem_we   (a_mem_we),
        .mem_a    (a_mem_a),
        .mem_wd   (a_mem_wd),
        .mem_rd   (a_mem_rd)
    );

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .m0       (b0.slave),
        .m1       (b1.slave),
        .m0_stall (b_stall),
        .mem_we   (b_mem_we),
        .mem_a    (b_mem_a),
        .mem_wd   (b_mem_wd),
        .mem_rd   (b_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory model: combinational read, write on the rising edge.
    assign a_mem_rd = dmem[a_mem_a[9:2]];
    assign b_mem_rd = 32'h0;
    always @(posedge clk) if (a_mem_we) dmem[a_mem_a[9:2]] <= a_mem_wd;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic idle_a();
        a0.req = 1'b0; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0;
        a1.req = 1'b0; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0;
    endtask

    function automatic logic [1:0] dual_seq4(input int i);
        if (i == 0) return 2'b00;
        return (((i - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        dmem[8'h10] = 32'hDEAD_BEEF;   // 0x40
        dmem[8'h11] = 32'h1111_1111;   // 0x44
        dmem[8'h21] = 32'hCAFE_F00D;   // 0x84
        idle_a();
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;

        // Reset state
        reset   = 1'b0;
        a0.req  = 1'b1;
        #3;
        check("rst_gnt0",   a0.gnt,   0);
        check("rst_gnt1",   a1.gnt,   0);
        check("rst_stall1", a_stall,  1);
        check("rst_we",     a_mem_we, 0);
        check("rst_addr",   a_mem_a,  0);
        a0.req = 1'b0;
        #1;
        check("rst_stall0", a_stall,  0);
        #8 reset = 1'b1;               // t=12, between edges
        cyc();

        // 1: lone core read
        a0.req = 1'b1; a0.we = 1'b0; a0.addr = 32'h40;
        obs();
        check("t1_c1_gnt",   a0.gnt,    0);
        check("t1_c1_stall", a_stall,   1);
        check("t1_c1_rv",    a0.rvalid, 0);
        cyc();
        obs();
        check("t1_c2_gnt",   a0.gnt,    1);
        check("t1_c2_stall", a_stall,   0);
        check("t1_c2_rv",    a0.rvalid, 1);
        check("t1_c2_rdata", a0.rdata,  32'hDEAD_BEEF);
        check("t1_c2_mema",  a_mem_a,   32'h40);
        cyc();
        idle_a();
        obs();
        check("t1_rel_rv",   a0.rvalid, 0);
        check("t1_rel_mema", a_mem_a,   0);
        cyc();
        obs();
        check("t1_idle_gnt", a0.gnt,    0);

        // 2: simultaneous requests from reset, bursts of 4
        reset = 1'b0;
        #2 reset = 1'b1;
        cyc();
        a0.req = 1'b1; a0.addr = 32'h40;
        a1.req = 1'b1; a1.addr = 32'h44;
        for (int i = 0; i <= 16; i++) begin
            obs();
            check($sformatf("t2_gnt_%0d", i), {a1.gnt, a0.gnt}, dual_seq4(i));
            if (i == 5) begin
                check("t2_m1_rdata", a1.rdata, 32'h1111_1111);
                check("t2_m0_rdata", a0.rdata, 32'h0);
            end
            cyc();
        end
        idle_a();
        cyc();

        // 3: uncontested loader write held past MAX_BURST, then core reads it
        a1.req = 1'b1; a1.we = 1'b1; a1.addr = 32'h80; a1.wdata = 32'h1234_5678;
        obs();
        check("t3_wait_gnt1", a1.gnt, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            obs();
            check($sformatf("t3_hold_%0d", k), a1.gnt, 1);
            if (k == 1) begin
                check("t3_mem_we", a_mem_we, 1);
                check("t3_mem_a",  a_mem_a,  32'h80);
                check("t3_mem_wd", a_mem_wd, 32'h1234_5678);
            end
        end
        cyc();
        idle_a();
        a0.req = 1'b1; a0.addr = 32'h80;
        obs();
        check("t3_ho_stall", a_stall,  1);
        check("t3_ho_we",    a_mem_we, 0);
        cyc();
        obs();
        check("t3_rd_gnt0",  a0.gnt,    1);
        check("t3_rd_gnt1",  a1.gnt,    0);
        check("t3_rd_rv",    a0.rvalid, 1);
        check("t3_rd_data",  a0.rdata,  32'h1234_5678);

        // 4: core drops after one contested beat; loader gets a fresh burst
        cyc();
        idle_a();
        cyc();
        a0.req = 1'b1; a0.addr = 32'h40;
        cyc();
        a1.req = 1'b1; a1.addr = 32'h44;
        obs();
        check("t4_beat_gnt0", a0.gnt, 1);
        cyc();
        a0.req = 1'b0;
        obs();
        check("t4_drop_gnt", {a1.gnt, a0.gnt}, 2'b01);
        check("t4_drop_mema", a_mem_a, 0);
        cyc();
        a0.req = 1'b1;
        for (int j = 0; j <= 4; j++) begin
            obs();
            check($sformatf("t4_gnt_%0d", j), {a1.gnt, a0.gnt}, (j < 4) ? 2'b10 : 2'b01);
            cyc();
        end

        // 5: reset during a loader write beat
        idle_a();
        cyc();
        a0.req = 1'b1; a0.addr = 32'h40;
        a1.req = 1'b1; a1.we = 1'b1; a1.addr = 32'h84; a1.wdata = 32'hAAAA_5555;
        obs();
        check("t5_idle_gnt", {a1.gnt, a0.gnt}, 2'b00);
        cyc();
        check("t5_own1",    {a1.gnt, a0.gnt}, 2'b10);
        check("t5_we_pre",  a_mem_we, 1);
        #1 reset = 1'b0;
        #1;
        check("t5_we_rst",   a_mem_we, 0);
        check("t5_gnt_rst",  {a1.gnt, a0.gnt}, 2'b00);
        check("t5_stall_rst", a_stall, 1);
        check("t5_mema_rst", a_mem_a, 0);
        cyc();
        check("t5_dmem_kept", dmem[8'h21], 32'hCAFE_F00D);
        reset = 1'b1;
        obs();
        check("t5_rel_idle", {a1.gnt, a0.gnt}, 2'b00);
        cyc();
        obs();
        check("t5_core_first", {a1.gnt, a0.gnt}, 2'b01);
        check("t5_dmem_after", dmem[8'h21], 32'hCAFE_F00D);
        cyc();
        idle_a();

        // 6: MAX_BURST=1 alternates every cycle
        b0.req = 1'b1; b0.addr = 32'h10;
        b1.req = 1'b1; b1.addr = 32'h20;
        for (int i = 0; i <= 6; i++) begin
            obs();
            check($sformatf("t6_gnt_%0d", i), {b1.gnt, b0.gnt},
                  (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
